icache_responder: RTL

- Instruction-side responder for the fetch PC stream.
- Reads a direct-mapped array synchronously at the next-PC index. Compares the tag against the current PC. Returns the instruction word in the cycle that PC is current.
- On a miss, raises a stall and refills the whole line from the memory port with a small FSM.
- Sits between the fetch stage and the instruction memory.

---
 rtl/icache_responder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache responder for the fetch PC stream.
//
// The tag/data arrays are read synchronously at the index of i_pc_next, so the
// line is available one cycle later, when that PC has become i_pc_current.
// A miss raises o_miss and a small FSM (IDLE -> REQUEST -> REFILL -> REPLAY)
// refills the whole line from the memory port. REPLAY spends one cycle so the
// synchronous read picks up the freshly written line before hits resume.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_pc_next                   next PC, indexes the synchronous array read
//   i_pc_current                current PC, supplies tag and word select
//   i_req                       fetch request valid for i_pc_current
//   o_data / o_valid            instruction word and hit indication
//   o_miss                      stall request to hazard control
//   mem_req_valid/addr/ready    line refill request handshake (line-aligned address)
//   mem_resp_valid/data         refill beats, words in ascending order
//
// Optional build macro ICACHE_PERF_CNT_EN adds saturating 32-bit o_hit_count
// and o_miss_count outputs.

module icache_responder #(
  parameter int ADDR_WIDTH         = 26,
  parameter int DATA_WIDTH         = 32,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_pc_next,
  input  logic [ADDR_WIDTH-1:0] i_pc_current,
  input  logic                  i_req,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_miss,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
`endif
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << BLOCK_OFFSET_WIDTH;
  localparam int WORD_LSB  = 2;
  localparam int IDX_LSB   = WORD_LSB + BLOCK_OFFSET_WIDTH;
  localparam int TAG_LSB   = IDX_LSB + INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;
  localparam int LINE_W    = ADDR_WIDTH - IDX_LSB;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_REFILL  = 2'd2,
    S_REPLAY  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [LINE_W-1:0]             line_q, line_d;     // tag+index of the line being refilled
  logic [BLOCK_OFFSET_WIDTH-1:0] count_q, count_d;
  logic [LINES-1:0]              valid_q;

  logic [TAG_WIDTH-1:0]          tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]         data_mem [LINES][WORDS];
  logic [TAG_WIDTH-1:0]          rd_tag_q;
  logic [DATA_WIDTH-1:0]         rd_line_q [WORDS];

  logic [INDEX_WIDTH-1:0]        rd_idx_s, cur_idx_s, fill_idx_s;
  logic [TAG_WIDTH-1:0]          cur_tag_s;
  logic [BLOCK_OFFSET_WIDTH-1:0] cur_word_s;
  logic                          hit_s, beat_s, last_beat_s;
  logic                          unused_s;

  assign rd_idx_s    = i_pc_next[IDX_LSB +: INDEX_WIDTH];
  assign cur_idx_s   = i_pc_current[IDX_LSB +: INDEX_WIDTH];
  assign cur_tag_s   = i_pc_current[TAG_LSB +: TAG_WIDTH];
  assign cur_word_s  = i_pc_current[WORD_LSB +: BLOCK_OFFSET_WIDTH];
  assign fill_idx_s  = line_q[INDEX_WIDTH-1:0];
  assign beat_s      = (state_q == S_REFILL) && mem_resp_valid;
  assign last_beat_s = beat_s && (count_q == {BLOCK_OFFSET_WIDTH{1'b1}});
  assign unused_s    = ^{i_pc_next[IDX_LSB-1:0], i_pc_next[ADDR_WIDTH-1:TAG_LSB],
                         i_pc_current[WORD_LSB-1:0]};

  // Hit is only trusted in IDLE: during a refill the registered read may hold stale data.
  assign hit_s = i_req && valid_q[cur_idx_s] && (rd_tag_q == cur_tag_s) && (state_q == S_IDLE);

  // Fetch-side outputs; o_miss is forced low while reset is asserted.
  always_comb begin
    o_valid = 1'b0;
    o_data  = {DATA_WIDTH{1'b0}};
    o_miss  = 1'b0;
    if (hit_s) begin
      o_valid = 1'b1;
      o_data  = rd_line_q[cur_word_s];
    end else begin
      o_valid = 1'b0;
      o_data  = {DATA_WIDTH{1'b0}};
    end
    if (rst_n && i_req && !hit_s) begin
      o_miss = 1'b1;
    end else begin
      o_miss = 1'b0;
    end
  end

  // Memory request comes straight from state/line registers, so async reset drops it at once.
  assign mem_req_valid = (state_q == S_REQUEST);
  assign mem_req_addr  = {line_q, {IDX_LSB{1'b0}}};

  // Refill FSM next-state logic.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (o_miss) begin
          line_d  = i_pc_current[ADDR_WIDTH-1:IDX_LSB];
          state_d = S_REQUEST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQUEST: begin
        if (mem_req_ready) begin
          count_d = {BLOCK_OFFSET_WIDTH{1'b0}};
          state_d = S_REFILL;
        end else begin
          state_d = S_REQUEST;
        end
      end
      S_REFILL: begin
        if (beat_s) begin
          count_d = count_q + {{(BLOCK_OFFSET_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          count_d = count_q;
        end
        if (last_beat_s) begin
          state_d = S_REPLAY;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REPLAY: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state, refill line address, beat counter and line valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= {LINE_W{1'b0}};
      count_q <= {BLOCK_OFFSET_WIDTH{1'b0}};
      valid_q <= {LINES{1'b0}};
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      count_q <= count_d;
      if (last_beat_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag/data arrays (not reset) with synchronous read; a same-cycle write returns old contents.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_mem[fill_idx_s][count_q] <= mem_resp_data;
    end
    if (last_beat_s) begin
      tag_mem[fill_idx_s] <= line_q[LINE_W-1:INDEX_WIDTH];
    end
    rd_tag_q <= tag_mem[rd_idx_s];
    for (int w = 0; w < WORDS; w++) begin
      rd_line_q[w] <= data_mem[rd_idx_s][w];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == S_IDLE) && o_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

endmodule
